msg_frame_rd: RTL and testbench

MSG_FRAME_RD -- requirements
Module: msg_frame_rd

---
 rtl/msg_frame_rd.sv | 234 +++++++++++++++++++++++
 tb/tb_msg_frame_rd.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_frame_rd.sv
// Byte-stream frame parser: pulls bytes from an RX FIFO, decodes write/read/burst-write
// frames and issues single-cycle OPB strobes; errors are pulsed, latched and counted.
module msg_frame_rd #(
  parameter int unsigned ADDR_BYTES     = 4,
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned TIMEOUT_PULSES = 200,
  parameter bit          CHK_EN         = 1'b0
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        PULSE_2KHZ,
  output logic        RX_FIFO_RD,
  input  logic [7:0]  RX_FIFO_DATA,
  input  logic        RX_FIFO_EMPTY,
  output logic [31:0] OPB_ADDR,
  output logic [31:0] OPB_DO,
  output logic        OPB_WE,
  output logic        OPB_RE,
  output logic        error_flag,
  output logic [2:0]  error_code,
  output logic [7:0]  error_cnt
);

  localparam int unsigned TW    = $clog2(TIMEOUT_PULSES + 1);
  localparam logic [1:0]  ALast = 2'(ADDR_BYTES - 1);
  localparam logic [1:0]  DLast = 2'(DATA_BYTES - 1);

  typedef enum logic [2:0] {StHunt, StLen, StAddr, StData, StChk, StTail} state_e;
  typedef enum logic [1:0] {KWrite, KRead, KBurst} kind_e;

  state_e        state_q, state_d;
  kind_e         kind_q, kind_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    words_q, words_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pulse_q;
  logic          rd_q, rd_d;
  logic          vld_q;
  logic [31:0]   oaddr_q, oaddr_d;
  logic [31:0]   odo_q, odo_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic          eflag_q, eflag_d;
  logic [2:0]    ecode_q, ecode_d;
  logic [7:0]    ecnt_q, ecnt_d;

  logic          rise;
  logic          err;
  logic [2:0]    err_code;
  logic [7:0]    tail_exp;
  logic [7:0]    rx;
  logic [31:0]   data_nxt;

  assign rise     = PULSE_2KHZ & ~pulse_q;
  assign rx       = RX_FIFO_DATA;
  assign data_nxt = {data_q[23:0], rx};
  assign tail_exp = (kind_q == KRead) ? 8'hA4 : 8'hA5;

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    idx_d    = idx_q;
    words_d  = words_q;
    addr_d   = addr_q;
    data_d   = data_q;
    chk_d    = chk_q;
    tmo_d    = tmo_q;
    oaddr_d  = oaddr_q;
    odo_d    = odo_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    eflag_d  = 1'b0;
    ecode_d  = ecode_q;
    ecnt_d   = ecnt_q;
    err      = 1'b0;
    err_code = 3'd0;
    // A new read is only issued once the previous byte has been sampled.
    rd_d     = ~RX_FIFO_EMPTY & ~rd_q;

    if (vld_q) begin
      tmo_d = '0;
      chk_d = chk_q ^ rx;
      unique case (state_q)
        StHunt: begin
          chk_d  = rx;
          idx_d  = 2'd0;
          addr_d = '0;
          data_d = '0;
          if (rx == 8'h5A) begin
            kind_d  = KWrite;
            state_d = StAddr;
          end else if (rx == 8'h5B) begin
            kind_d  = KRead;
            state_d = StAddr;
          end else if (rx == 8'h5C) begin
            kind_d  = KBurst;
            state_d = StLen;
          end
        end
        StLen: begin
          if (rx == 8'h00) begin
            err      = 1'b1;
            err_code = 3'd4;
          end else begin
            words_d = rx;
            state_d = StAddr;
          end
        end
        StAddr: begin
          addr_d = {addr_q[23:0], rx};
          idx_d  = idx_q + 2'd1;
          if (idx_q == ALast) begin
            idx_d   = 2'd0;
            state_d = StData;
          end
        end
        StData: begin
          data_d = data_nxt;
          idx_d  = idx_q + 2'd1;
          if (idx_q == DLast) begin
            idx_d = 2'd0;
            if (kind_q == KBurst) begin
              // Burst words are written as they complete; the address walks upward.
              we_d    = 1'b1;
              oaddr_d = addr_q;
              odo_d   = data_nxt;
              addr_d  = addr_q + 32'(DATA_BYTES);
              data_d  = '0;
              words_d = words_q - 8'd1;
              if (words_q == 8'd1) state_d = CHK_EN ? StChk : StTail;
            end else begin
              state_d = CHK_EN ? StChk : StTail;
            end
          end
        end
        StChk: begin
          if (rx != chk_q) begin
            err      = 1'b1;
            err_code = 3'd3;
          end else begin
            state_d = StTail;
          end
        end
        StTail: begin
          if (rx != tail_exp) begin
            err      = 1'b1;
            err_code = 3'd1;
          end else begin
            state_d = StHunt;
            if (kind_q == KWrite) begin
              we_d    = 1'b1;
              oaddr_d = addr_q;
              odo_d   = data_q;
            end else if (kind_q == KRead) begin
              re_d    = 1'b1;
              oaddr_d = addr_q;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end else if (state_q != StHunt && rise) begin
      if (tmo_q == TW'(TIMEOUT_PULSES - 1)) begin
        err      = 1'b1;
        err_code = 3'd2;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (err) begin
      eflag_d = 1'b1;
      ecode_d = err_code;
      ecnt_d  = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
      state_d = StHunt;
    end
    if (state_d == StHunt) tmo_d = '0;
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      state_q <= StHunt;
      kind_q  <= KWrite;
      idx_q   <= 2'd0;
      words_q <= 8'd0;
      addr_q  <= '0;
      data_q  <= '0;
      chk_q   <= 8'd0;
      tmo_q   <= '0;
      pulse_q <= 1'b0;
      rd_q    <= 1'b0;
      vld_q   <= 1'b0;
      oaddr_q <= '0;
      odo_q   <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      eflag_q <= 1'b0;
      ecode_q <= 3'd0;
      ecnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      chk_q   <= chk_d;
      tmo_q   <= tmo_d;
      pulse_q <= PULSE_2KHZ;
      rd_q    <= rd_d;
      vld_q   <= rd_q;
      oaddr_q <= oaddr_d;
      odo_q   <= odo_d;
      we_q    <= we_d;
      re_q    <= re_d;
      eflag_q <= eflag_d;
      ecode_q <= ecode_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign RX_FIFO_RD = rd_q;
  assign OPB_ADDR   = oaddr_q;
  assign OPB_DO     = odo_q;
  assign OPB_WE     = we_q;
  assign OPB_RE     = re_q;
  assign error_flag = eflag_q;
  assign error_code = ecode_q;
  assign error_cnt  = ecnt_q;

endmodule

// File: tb/tb_msg_frame_rd.sv
// Scoreboard bench for msg_frame_rd: a default instance and a 2/2-byte checksummed instance,
// each fed from a queue-based FIFO model; expected strobes/errors come from frame intent.
module tb_msg_frame_rd;

  typedef struct {
    int          kind;  // 0 write, 1 read, 2 error
    logic [31:0] addr;
    logic [31:0] dat;
    logic [2:0]  code;
    logic [7:0]  cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse = 1'b0;

  logic        rd0, we0, re0, ef0, emp0 = 1'b1;
  logic [7:0]  dat0 = 8'h00, ecnt0;
  logic [31:0] addr0, do0;
  logic [2:0]  ec0;
  logic        rd1, we1, re1, ef1, emp1 = 1'b1;
  logic [7:0]  dat1 = 8'h00, ecnt1;
  logic [31:0] addr1, do1;
  logic [2:0]  ec1;

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  ev_t        expq0[$];
  ev_t        expq1[$];
  logic [31:0] mdo[2];
  int          merr[2];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  msg_frame_rd u_dut0 (
    .OPB_CLK(clk), .OPB_RST(rst), .PULSE_2KHZ(pulse),
    .RX_FIFO_RD(rd0), .RX_FIFO_DATA(dat0), .RX_FIFO_EMPTY(emp0),
    .OPB_ADDR(addr0), .OPB_DO(do0), .OPB_WE(we0), .OPB_RE(re0),
    .error_flag(ef0), .error_code(ec0), .error_cnt(ecnt0)
  );

  msg_frame_rd #(.ADDR_BYTES(2), .DATA_BYTES(2), .TIMEOUT_PULSES(200), .CHK_EN(1'b1)) u_dut1 (
    .OPB_CLK(clk), .OPB_RST(rst), .PULSE_2KHZ(pulse),
    .RX_FIFO_RD(rd1), .RX_FIFO_DATA(dat1), .RX_FIFO_EMPTY(emp1),
    .OPB_ADDR(addr1), .OPB_DO(do1), .OPB_WE(we1), .OPB_RE(re1),
    .error_flag(ef1), .error_code(ec1), .error_cnt(ecnt1)
  );

  // FIFO models: data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (rd0 && fq0.size() > 0) dat0 <= fq0.pop_front();
    emp0 <= (fq0.size() == 0);
  end
  always @(posedge clk) begin
    if (rd1 && fq1.size() > 0) dat1 <= fq1.pop_front();
    emp1 <= (fq1.size() == 0);
  end

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic observe(input int inst, input ev_t a);
    ev_t e;
    bit  ok;
    n_chk++;
    if ((inst == 0 && expq0.size() == 0) || (inst == 1 && expq1.size() == 0)) begin
      $display("FAIL unexpected_event inst%0d: actual kind=%0d addr=%h do=%h code=%0d required none",
               inst, a.kind, a.addr, a.dat, a.code);
      return;
    end
    e = (inst == 0) ? expq0.pop_front() : expq1.pop_front();
    ok = (a.kind == e.kind) &&
         ((e.kind == 2) ? (a.code == e.code && a.cnt == e.cnt) : (a.addr == e.addr && a.dat == e.dat));
    if (ok) n_pass++;
    else $display("FAIL event inst%0d: actual kind=%0d addr=%h do=%h code=%0d cnt=%0d required kind=%0d addr=%h do=%h code=%0d cnt=%0d",
                  inst, a.kind, a.addr, a.dat, a.code, a.cnt, e.kind, e.addr, e.dat, e.code, e.cnt);
  endtask

  function automatic ev_t mk(input logic [2:0] w, input logic [31:0] ad, input logic [31:0] dt, input logic [2:0] cd, input logic [7:0] cn);
    ev_t e;
    e.kind = (w == 3'b100) ? 0 : (w == 3'b010) ? 1 : (w == 3'b001) ? 2 : 3;
    e.addr = ad; e.dat = dt; e.code = cd; e.cnt = cn;
    return e;
  endfunction

  always @(negedge clk) if (!rst && (we0 || re0 || ef0)) observe(0, mk({we0, re0, ef0}, addr0, do0, ec0, ecnt0));
  always @(negedge clk) if (!rst && (we1 || re1 || ef1)) observe(1, mk({we1, re1, ef1}, addr1, do1, ec1, ecnt1));

  task automatic push_exp(input int inst, input ev_t e);
    if (inst == 0) expq0.push_back(e); else expq1.push_back(e);
  endtask

  task automatic push_byte(input int inst, input logic [7:0] b);
    if (inst == 0) fq0.push_back(b); else fq1.push_back(b);
  endtask

  task automatic exp_err(input int inst, input logic [2:0] code);
    ev_t e;
    if (merr[inst] < 255) merr[inst]++;
    e.kind = 2; e.addr = '0; e.dat = '0; e.code = code; e.cnt = 8'(merr[inst]);
    push_exp(inst, e);
  endtask

  task automatic exp_strobe(input int inst, input int kind, input logic [31:0] ad, input logic [31:0] dt);
    ev_t e;
    e.kind = kind; e.addr = ad; e.dat = dt; e.code = 3'd0; e.cnt = 8'd0;
    push_exp(inst, e);
  endtask

  function automatic logic [31:0] mask(input int nb);
    return (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
  endfunction

  // kind: 0 write 5A, 1 read 5B, 2 burst 5C. bad_tail: 0 good, 1 other tail, 2 random corruption.
  task automatic send_frame(input int inst, input int kind, input logic [31:0] addr,
                            input logic [31:0] d0, input int len, input int bad_tail,
                            input bit bad_chk, input int garbage);
    int          nba = (inst == 0) ? 4 : 2;
    int          nbd = (inst == 0) ? 4 : 2;
    bit          chk = (inst == 1);
    logic [7:0]  b, x, tl;
    logic [31:0] a, dw, d0m;
    int          nw;
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom);
      if (b == 8'h5A || b == 8'h5B || b == 8'h5C) b = 8'hFF;
      push_byte(inst, b);
    end
    b = (kind == 0) ? 8'h5A : (kind == 1) ? 8'h5B : 8'h5C;
    push_byte(inst, b);
    x = b;
    if (kind == 2) begin
      push_byte(inst, 8'(len));
      x ^= 8'(len);
      if (len == 0) begin
        exp_err(inst, 3'd4);
        return;
      end
    end
    a = addr & mask(nba);
    for (int i = nba - 1; i >= 0; i--) begin
      b = a[8*i +: 8];
      push_byte(inst, b);
      x ^= b;
    end
    nw  = (kind == 2) ? len : 1;
    d0m = d0 & mask(nbd);
    for (int w = 0; w < nw; w++) begin
      dw = (w == 0) ? d0m : ($urandom & mask(nbd));
      for (int i = nbd - 1; i >= 0; i--) begin
        b = dw[8*i +: 8];
        push_byte(inst, b);
        x ^= b;
      end
      if (kind == 2) begin
        exp_strobe(inst, 0, a + 32'(w * nbd), dw);
        mdo[inst] = dw;
      end
    end
    if (chk) push_byte(inst, bad_chk ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
    tl = (kind == 1) ? 8'hA4 : 8'hA5;
    if (bad_tail == 1) tl = (kind == 1) ? 8'hA5 : 8'hA4;
    else if (bad_tail == 2) tl = tl ^ 8'(1 + $urandom_range(0, 254));
    push_byte(inst, tl);
    if (chk && bad_chk) exp_err(inst, 3'd3);
    else if (bad_tail != 0) exp_err(inst, 3'd1);
    else if (kind == 0) begin
      exp_strobe(inst, 0, a, d0m);
      mdo[inst] = d0m;
    end else if (kind == 1) exp_strobe(inst, 1, a, mdo[inst]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((fq0.size() + fq1.size() + expq0.size() + expq1.size()) != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("idle_wait", 1'b0, longint'(expq0.size() + expq1.size()), 0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int rises;
    mdo[0] = '0; mdo[1] = '0; merr[0] = 0; merr[1] = 0;
    repeat (3) @(negedge clk);
    check("rst_strobes0", {rd0, we0, re0, ef0} == 4'd0, longint'({rd0, we0, re0, ef0}), 0);
    check("rst_addr_do0", {addr0, do0} == 64'd0, longint'({addr0, do0}), 0);
    check("rst_err0", {ec0, ecnt0} == 11'd0, longint'({ec0, ecnt0}), 0);
    check("rst_all1", {rd1, we1, re1, ef1, addr1, do1, ec1, ecnt1} == '0,
          longint'({addr1, do1}), 0);
    rst = 1'b0;

    // Directed frames on the default instance.
    send_frame(0, 0, 32'hAABBCCDD, 32'h11223344, 0, 0, 1'b0, 0);
    send_frame(0, 1, 32'h12345678, 32'hAABBCCDD, 0, 0, 1'b0, 3);
    send_frame(0, 1, 32'h12345678, 32'hAABBCCDD, 0, 1, 1'b0, 0);
    send_frame(0, 0, 32'h00000040, 32'hCAFEF00D, 0, 0, 1'b0, 0);
    send_frame(0, 2, 32'h00001000, $urandom, 3, 0, 1'b0, 0);
    send_frame(0, 2, 32'h00000000, 32'h0, 0, 0, 1'b0, 0);
    send_frame(0, 2, 32'hFFFFFFFC, $urandom, 2, 0, 1'b0, 0);
    wait_idle();
    check("err_cnt_directed0", ecnt0 == 8'(merr[0]), longint'(ecnt0), longint'(merr[0]));

    // Checksummed instance.
    send_frame(1, 0, 32'h00001234, 32'h0000ABCD, 0, 0, 1'b0, 0);
    send_frame(1, 0, 32'h00001234, 32'h0000ABCD, 0, 0, 1'b1, 0);
    send_frame(1, 1, 32'h00005678, 32'h0, 0, 0, 1'b0, 1);
    send_frame(1, 2, 32'h00000100, $urandom, 2, 0, 1'b0, 0);
    send_frame(1, 2, 32'h00000200, $urandom, 2, 0, 1'b1, 0);
    wait_idle();
    check("err_code1", ec1 == 3'd3, longint'(ec1), 3);

    // Randomized frames on both instances.
    for (int i = 0; i < 60; i++) begin
      int inst = $urandom_range(0, 1);
      int kind = $urandom_range(0, 2);
      int bt   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
      send_frame(inst, kind, $urandom, $urandom, $urandom_range(0, 4), bt,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2));
      if (i % 10 == 9) wait_idle();
    end
    wait_idle();
    check("err_cnt_rand0", ecnt0 == 8'(merr[0]), longint'(ecnt0), longint'(merr[0]));
    check("err_cnt_rand1", ecnt1 == 8'(merr[1]), longint'(ecnt1), longint'(merr[1]));

    // Timeout: stalled frame, then count slow-timebase rising edges until the error.
    push_byte(0, 8'h5A); push_byte(0, 8'hAA); push_byte(0, 8'hBB);
    push_byte(0, 8'hCC); push_byte(0, 8'hDD);
    exp_err(0, 3'd2);
    for (int n = 0; n < 200 && fq0.size() != 0; n++) @(negedge clk);
    repeat (6) @(negedge clk);
    rises = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (ef0) break;
      pulse = ~pulse;
      if (pulse) rises++;
    end
    pulse = 1'b0;
    check("timeout_pulses", rises == 200, longint'(rises), 200);
    wait_idle();
    check("timeout_code", ec0 == 3'd2, longint'(ec0), 2);

    // Reset in the middle of a frame abandons it silently.
    push_byte(0, 8'h5A); push_byte(0, 8'h01); push_byte(0, 8'h02);
    for (int n = 0; n < 200 && fq0.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdo[0] = '0; mdo[1] = '0; merr[0] = 0; merr[1] = 0;
    check("midrst_err", {ec0, ecnt0} == 11'd0, longint'({ec0, ecnt0}), 0);
    check("midrst_addr", addr0 == 32'd0, longint'(addr0), 0);
    repeat (20) @(negedge clk);
    send_frame(0, 0, 32'h01020304, 32'h05060708, 0, 0, 1'b0, 0);
    wait_idle();
    check("post_rst_addr", addr0 == 32'h01020304, longint'(addr0), 32'h01020304);
    check("post_rst_cnt", ecnt0 == 8'd0, longint'(ecnt0), 0);
    check("scoreboard_empty", (expq0.size() + expq1.size()) == 0,
          longint'(expq0.size() + expq1.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
